exe_branch_unit: RTL
====================

EXE_BRANCH_UNIT -- requirements
Module: exe_branch_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 Parameter ADDR_WIDTH, default 32, instruction address width.
REQ-003 Parameter BHT_DEPTH, default 16, branch history table entries; power of 2, 2..256.
REQ-004 Parameter CNT_WIDTH, default 32, mispredict counter width.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 clk_i  in  1  clock.
REQ-007 rst_i  in  1  asynchronous active-high reset.
REQ-008 valid_i  in  1  instruction present this cycle.
REQ-009 stall_i  in  1  hold outputs and table; no capture.
REQ-010 inst_i  in  32  instruction word.
REQ-011 inst_addr_i  in  ADDR_WIDTH  instruction PC.
REQ-012 op1_i / op2_i  in  DATA_WIDTH  rs1 / rs2 values.
REQ-013 pred_taken_i  in  1  direction predicted by fetch.
REQ-014 lookup_addr_i  in  ADDR_WIDTH  fetch PC for prediction.
REQ-015 lookup_taken_o  out  1  combinational prediction for lookup_addr_i.
REQ-016 valid_o  out  1  registered result valid.
REQ-017 reg_we_o / reg_wdata_o  out  1 / DATA_WIDTH  link register write.
REQ-018 jump_we_o / jump_addr_o  out  1 / ADDR_WIDTH  redirect request and target.
REQ-019 mispredict_o  out  1  redirect caused by direction mispredict.
REQ-020 misalign_o  out  1  taken target not 4-byte aligned.
REQ-021 mispredict_cnt_o  out  CNT_WIDTH  total mispredicts.

Function
REQ-022 Capture on valid_i=1 and stall_i=0; results appear one cycle later with valid_o=1.
REQ-023 valid_i=0 and stall_i=0: next cycle valid_o, reg_we_o, jump_we_o, mispredict_o, misalign_o = 0, data outputs 0.
REQ-024 stall_i=1: all registered outputs, table and counter hold.
REQ-025 JAL: target = PC + sign-extended J-immediate; link = PC+4; jump_we_o=1 always.
REQ-026 JALR: target = (op1 + sign-extended I-immediate) with bit 0 cleared; link = PC+4; jump_we_o=1 always.
REQ-027 Branch funct3 BEQ/BNE/BLT/BGE (signed)/BLTU/BGEU (unsigned) gives taken; reg_we_o=0.
REQ-028 Branch, taken != pred_taken_i: jump_we_o=1, mispredict_o=1, jump_addr_o = taken ? PC + B-immediate : PC+4.
REQ-029 Branch, taken == pred_taken_i: jump_we_o=0, jump_addr_o=0.
REQ-030 Undefined branch funct3 or other opcode: no writes, no redirect, no table update.
REQ-031 Taken target with bits[1:0] != 0: misalign_o=1, jump_we_o=0, reg_we_o=0, mispredict_o=0, counter unchanged.
REQ-032 Address arithmetic modulo 2^ADDR_WIDTH; wrap-around silent.
REQ-033 Table: BHT_DEPTH 2-bit saturating counters, index = PC[log2(BHT_DEPTH)+1:2].
REQ-034 Each captured conditional branch (not misaligned) updates its entry at the capture edge: taken increments (saturate 3), not-taken decrements (saturate 0).
REQ-035 lookup_taken_o = bit 1 of indexed counter; same-cycle update to that index is not visible until next cycle.
REQ-036 mispredict_cnt_o increments once per mispredict capture; wraps to 0 at all-ones.

Reset
REQ-037 rst_i=1 asynchronously clears all outputs to 0, mispredict_cnt_o to 0, every counter to 2'b01 (weakly not-taken).
REQ-038 Reset mid-operation discards the in-flight result; first capture after release behaves as from power-up.

Structure
REQ-039 Opcode, funct3 and WRITE_ENABLE/DISABLE constants come from the shared defines package; counter encodings added there.
REQ-040 Sub-module bht_2bit (counter array, lookup and update ports) instantiated once.

Verification
REQ-041 After reset, lookup_addr_i=0x40 -> lookup_taken_o=0; JAL at PC 0x100, imm +0x20 -> jump_addr_o=0x120, reg_wdata_o=0x104, jump_we_o=1 next cycle.
REQ-042 BEQ op1=op2=5, PC 0x200, imm -8, pred_taken_i=0 -> jump_addr_o=0x1F8, mispredict_o=1, mispredict_cnt_o=1.
REQ-043 BLTU op1=0xFFFFFFFF, op2=1, pred_taken_i=0 -> jump_we_o=0; BLT same operands, pred 0 -> redirect to target.
REQ-044 Same-PC taken branch 3 times -> counter 3, lookup_taken_o=1; 1 not-taken -> still 1; 2 more not-taken -> 0.
REQ-045 JALR op1=0x1001, imm 2 -> jump_addr_o=0x1002, misalign_o=1, jump_we_o=0, reg_we_o=0.
REQ-046 stall_i=1 for 3 cycles during a captured BNE -> outputs held; rst_i pulse mid-hold -> all outputs 0 immediately.

Source files
------------

// File: rtl/exe_branch_unit_pkg.sv
// Shared definitions for the execute-stage branch unit: opcodes, funct3 codes,
// write-enable levels, 2-bit predictor encodings and immediate decoders.
package exe_branch_unit_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    typedef enum logic [1:0] {
        BHT_SNT = 2'b00,
        BHT_WNT = 2'b01,
        BHT_WT  = 2'b10,
        BHT_ST  = 2'b11
    } bht_cnt_e;

    localparam bht_cnt_e BHT_RESET = BHT_WNT;

    function automatic logic [31:0] imm_i(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:20]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    // Saturating 2-bit counter step: taken moves toward BHT_ST, not-taken toward BHT_SNT.
    function automatic bht_cnt_e bht_next(input bht_cnt_e cnt, input logic taken);
        bht_cnt_e nxt;
        nxt = cnt;
        case (cnt)
            BHT_SNT: nxt = taken ? BHT_WNT : BHT_SNT;
            BHT_WNT: nxt = taken ? BHT_WT  : BHT_SNT;
            BHT_WT:  nxt = taken ? BHT_ST  : BHT_WNT;
            BHT_ST:  nxt = taken ? BHT_ST  : BHT_WT;
            default: nxt = BHT_RESET;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters with one combinational
// lookup port and one update port written on the clock edge.
module bht_2bit
    import exe_branch_unit_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IDX_W-1:0] lookup_idx_i,
    output logic             lookup_taken_o,
    input  logic             upd_en_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i
);

    bht_cnt_e cnt_q [DEPTH];

    assign lookup_taken_o = cnt_q[lookup_idx_i][1];

    // Counter array: reset to weakly not-taken, one saturating step per update.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= BHT_RESET;
            end
        end else if (upd_en_i) begin
            cnt_q[upd_idx_i] <= bht_next(cnt_q[upd_idx_i], upd_taken_i);
        end
    end

endmodule

// File: rtl/exe_branch_unit.sv
// Execute-stage branch/jump resolution: computes JAL/JALR/branch targets,
// resolves direction mispredicts, trains the BHT and counts mispredicts.
module exe_branch_unit
    import exe_branch_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int BHT_DEPTH  = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic                  stall_i,
    input  logic [31:0]           inst_i,
    input  logic [ADDR_WIDTH-1:0] inst_addr_i,
    input  logic [DATA_WIDTH-1:0] op1_i,
    input  logic [DATA_WIDTH-1:0] op2_i,
    input  logic                  pred_taken_i,
    input  logic [ADDR_WIDTH-1:0] lookup_addr_i,
    output logic                  lookup_taken_o,
    output logic                  valid_o,
    output logic                  reg_we_o,
    output logic [DATA_WIDTH-1:0] reg_wdata_o,
    output logic                  jump_we_o,
    output logic [ADDR_WIDTH-1:0] jump_addr_o,
    output logic                  mispredict_o,
    output logic                  misalign_o,
    output logic [CNT_WIDTH-1:0]  mispredict_cnt_o
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [6:0]            opcode_s;
    logic [2:0]            funct3_s;
    logic                  capture_s;
    logic [ADDR_WIDTH-1:0] link_s;
    logic [ADDR_WIDTH-1:0] jal_tgt_s;
    logic [ADDR_WIDTH-1:0] jalr_sum_s;
    logic [ADDR_WIDTH-1:0] jalr_tgt_s;
    logic [ADDR_WIDTH-1:0] jmp_tgt_s;
    logic [ADDR_WIDTH-1:0] br_tgt_s;
    logic [ADDR_WIDTH-1:0] br_dest_s;
    logic                  br_known_s;
    logic                  br_taken_s;
    logic                  bht_upd_s;
    logic                  lookup_unused_s;

    logic                  valid_d, valid_q;
    logic                  reg_we_d, reg_we_q;
    logic [DATA_WIDTH-1:0] reg_wdata_d, reg_wdata_q;
    logic                  jump_we_d, jump_we_q;
    logic [ADDR_WIDTH-1:0] jump_addr_d, jump_addr_q;
    logic                  mispredict_d, mispredict_q;
    logic                  misalign_d, misalign_q;
    logic [CNT_WIDTH-1:0]  cnt_q;

    assign opcode_s   = inst_i[6:0];
    assign funct3_s   = inst_i[14:12];
    assign capture_s  = valid_i & ~stall_i;
    assign link_s     = inst_addr_i + ADDR_WIDTH'(32'd4);
    assign jal_tgt_s  = inst_addr_i + ADDR_WIDTH'($signed(imm_j(inst_i)));
    assign jalr_sum_s = ADDR_WIDTH'(op1_i) + ADDR_WIDTH'($signed(imm_i(inst_i)));
    assign jalr_tgt_s = {jalr_sum_s[ADDR_WIDTH-1:1], 1'b0};
    assign jmp_tgt_s  = (opcode_s == OPC_JAL) ? jal_tgt_s : jalr_tgt_s;
    assign br_tgt_s   = inst_addr_i + ADDR_WIDTH'($signed(imm_b(inst_i)));
    assign br_dest_s  = br_taken_s ? br_tgt_s : link_s;

    // Only the index bits of the fetch PC select a predictor entry.
    assign lookup_unused_s = ^{lookup_addr_i[ADDR_WIDTH-1:IDX_W+2], lookup_addr_i[1:0]};

    // Branch condition evaluation; unknown funct3 encodings are flagged.
    always_comb begin
        br_known_s = 1'b1;
        br_taken_s = 1'b0;
        case (funct3_s)
            F3_BEQ:  br_taken_s = (op1_i == op2_i);
            F3_BNE:  br_taken_s = (op1_i != op2_i);
            F3_BLT:  br_taken_s = ($signed(op1_i) <  $signed(op2_i));
            F3_BGE:  br_taken_s = ($signed(op1_i) >= $signed(op2_i));
            F3_BLTU: br_taken_s = (op1_i <  op2_i);
            F3_BGEU: br_taken_s = (op1_i >= op2_i);
            default: br_known_s = 1'b0;
        endcase
    end

    // Result next-state: zeros unless a capture produces writes or a redirect.
    always_comb begin
        valid_d      = 1'b0;
        reg_we_d     = WRITE_DISABLE;
        reg_wdata_d  = '0;
        jump_we_d    = WRITE_DISABLE;
        jump_addr_d  = '0;
        mispredict_d = 1'b0;
        misalign_d   = 1'b0;
        bht_upd_s    = 1'b0;
        if (capture_s) begin
            valid_d = 1'b1;
            case (opcode_s)
                OPC_JAL, OPC_JALR: begin
                    jump_addr_d = jmp_tgt_s;
                    if (jmp_tgt_s[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                    end else begin
                        jump_we_d   = WRITE_ENABLE;
                        reg_we_d    = WRITE_ENABLE;
                        reg_wdata_d = DATA_WIDTH'(link_s);
                    end
                end
                OPC_BRANCH: begin
                    if (!br_known_s) begin
                        valid_d = 1'b1;
                    end else if (br_taken_s && (br_tgt_s[1:0] != 2'b00)) begin
                        misalign_d  = 1'b1;
                        jump_addr_d = br_tgt_s;
                    end else begin
                        bht_upd_s = 1'b1;
                        if (br_taken_s != pred_taken_i) begin
                            jump_we_d    = WRITE_ENABLE;
                            mispredict_d = 1'b1;
                            jump_addr_d  = br_dest_s;
                        end else begin
                            jump_we_d = WRITE_DISABLE;
                        end
                    end
                end
                default: valid_d = 1'b1;
            endcase
        end else begin
            valid_d = 1'b0;
        end
    end

    // Output and mispredict-counter registers; a stall freezes everything.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q      <= 1'b0;
            reg_we_q     <= WRITE_DISABLE;
            reg_wdata_q  <= '0;
            jump_we_q    <= WRITE_DISABLE;
            jump_addr_q  <= '0;
            mispredict_q <= 1'b0;
            misalign_q   <= 1'b0;
            cnt_q        <= '0;
        end else if (!stall_i) begin
            valid_q      <= valid_d;
            reg_we_q     <= reg_we_d;
            reg_wdata_q  <= reg_wdata_d;
            jump_we_q    <= jump_we_d;
            jump_addr_q  <= jump_addr_d;
            mispredict_q <= mispredict_d;
            misalign_q   <= misalign_d;
            if (mispredict_d) begin
                cnt_q <= cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    bht_2bit #(
        .DEPTH (BHT_DEPTH),
        .IDX_W (IDX_W)
    ) u_bht (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .lookup_idx_i   (lookup_addr_i[IDX_W+1:2]),
        .lookup_taken_o (lookup_taken_o),
        .upd_en_i       (bht_upd_s),
        .upd_idx_i      (inst_addr_i[IDX_W+1:2]),
        .upd_taken_i    (br_taken_s)
    );

    assign valid_o          = valid_q;
    assign reg_we_o         = reg_we_q;
    assign reg_wdata_o      = reg_wdata_q;
    assign jump_we_o        = jump_we_q;
    assign jump_addr_o      = jump_addr_q;
    assign mispredict_o     = mispredict_q;
    assign misalign_o       = misalign_q;
    assign mispredict_cnt_o = cnt_q;

endmodule
